// File: rtl/park_event_tx.sv
// Parking-lot event serializer: arbitrates entry/exit requests, tracks occupancy and
// frames each accepted event onto x. Define PARK_TX_PARITY_EN to add an even-parity bit.
//
// state   | meaning
// S_IDLE  | line idle; arbitrates requests unless the frame just ended
// S_START | start bit (1)
// S_EVT   | event bit (1 entry, 0 exit)
// S_SLOT  | slot_id bits, MSB first
// S_PAR   | even parity over EVT+SLOT (PARK_TX_PARITY_EN only)
// S_STOP  | stop bit (0)
module park_event_tx #(
  parameter int SLOT_W     = 3,
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] slot_id,
  output logic              req_ack,
  output logic              req_rej,
  output logic              x,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int TMR_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_EVT, S_SLOT, S_PAR, S_STOP
  } state_t;

  state_t            r_state;
  logic [TMR_W-1:0]  r_tmr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_evt;
  logic [SLOT_W-1:0] r_slot;
  logic              r_x;
  logic              r_busy;
  logic              r_ack;
  logic              r_rej;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;

  logic w_bit;
  logic w_tc;

  // x is registered from the current state, so the line lags the state by one cycle
  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      S_START: w_bit = 1'b1;
      S_EVT:   w_bit = r_evt;
      S_SLOT:  w_bit = r_slot[r_idx];
      S_PAR:   w_bit = ^{r_evt, r_slot};
      default: w_bit = 1'b0;
    endcase
  end

  assign w_tc = (r_tmr == '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_evt   <= 1'b0;
      r_slot  <= '0;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rej   <= 1'b0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      r_rej <= 1'b0;
      r_x   <= w_bit;
      case (r_state)
        S_IDLE: begin
          // busy still high here means STOP just finished: forced idle cycle
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (entry_req && !r_full) begin
            r_state <= S_START;
            r_tmr   <= TMR_LOAD;
            r_evt   <= 1'b1;
            r_slot  <= slot_id;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= r_count + CNT_ONE;
            r_full  <= (r_count + CNT_ONE == CNT_MAX);
            r_empty <= 1'b0;
          end else if (exit_req && !r_empty) begin
            r_state <= S_START;
            r_tmr   <= TMR_LOAD;
            r_evt   <= 1'b0;
            r_slot  <= slot_id;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_count <= r_count - CNT_ONE;
            r_full  <= 1'b0;
            r_empty <= (r_count == CNT_ONE);
          end else if (entry_req || exit_req) begin
            r_rej <= 1'b1;
          end
        end
        default: begin
          if (w_tc) begin
            r_tmr <= TMR_LOAD;
            case (r_state)
              S_START: r_state <= S_EVT;
              S_EVT: begin
                r_state <= S_SLOT;
                r_idx   <= IDX_MSB;
              end
              S_SLOT: begin
                if (r_idx == '0) begin
`ifdef PARK_TX_PARITY_EN
                  r_state <= S_PAR;
`else
                  r_state <= S_STOP;
`endif
                end else begin
                  r_idx <= r_idx - 1'b1;
                end
              end
              S_PAR:   r_state <= S_STOP;
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ack = r_ack;
  assign req_rej = r_rej;
  assign x       = r_x;
  assign busy    = r_busy;
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: tb/tb_park_event_tx.sv
// Self-checking bench for park_event_tx: directed scenarios plus random request traffic
// checked against an occupancy/frame model. Honours PARK_TX_PARITY_EN.
module tb_park_event_tx;

`ifdef PARK_TX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, e = 1'b0, xr = 1'b0;
  logic [2:0] slot = 3'd0;
  logic       ack, rej, xo, busy, full, empty;
  logic [2:0] cnt;

  logic       rst3 = 1'b0, e3 = 1'b0, xr3 = 1'b0;
  logic [2:0] s3 = 3'd0;
  logic       ack3, rej3, x3, busy3, full3, empty3;
  logic [2:0] cnt3;

  park_event_tx #(.SLOT_W(3), .CAPACITY(7), .CNT_W(3), .BIT_CYCLES(1)) u_dut (
    .CLK(clk), .RESET(rst_a), .entry_req(e), .exit_req(xr), .slot_id(slot),
    .req_ack(ack), .req_rej(rej), .x(xo), .busy(busy), .count(cnt),
    .full(full), .empty(empty)
  );

  park_event_tx #(.SLOT_W(3), .CAPACITY(7), .CNT_W(3), .BIT_CYCLES(3)) u_b3 (
    .CLK(clk), .RESET(rst3), .entry_req(e3), .exit_req(xr3), .slot_id(s3),
    .req_ack(ack3), .req_rej(rej3), .x(x3), .busy(busy3), .count(cnt3),
    .full(full3), .empty(empty3)
  );

  int n_pass = 0;
  int n_total = 0;
  int m_count = 0;

  // Expected line bits, first bit at position NB-1
  function automatic logic [7:0] frame_bits(input logic ent, input logic [2:0] s);
`ifdef PARK_TX_PARITY_EN
    return {1'b0, 1'b1, ent, s, ^{ent, s}, 1'b0};
`else
    return {2'b00, 1'b1, ent, s, 1'b0};
`endif
  endfunction

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0; e = 1'b0; xr = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    m_count = 0;
  endtask

  task automatic txn(input logic te, input logic txr, input logic [2:0] ts,
                     input logic keep_exit, input string tag);
    logic exp_ent, exp_acc, exp_rej, stray, bz;
    logic [7:0] exp_f, cap;
    exp_ent = te && (m_count < 7);
    exp_acc = exp_ent || (txr && m_count > 0);
    exp_rej = !exp_acc && (te || txr);
    if (exp_acc) m_count += exp_ent ? 1 : -1;
    @(negedge clk);
    e = te; xr = txr; slot = ts;
    @(posedge clk); #1;
    n_total++;
    if ({ack, rej, busy} !== {exp_acc, exp_rej, exp_acc})
      $display("FAIL %s handshake: ack/rej/busy=%b%b%b expected %b%b%b",
               tag, ack, rej, busy, exp_acc, exp_rej, exp_acc);
    else n_pass++;
    n_total++;
    if ({cnt, full, empty} !== {3'(m_count), (m_count == 7), (m_count == 0)})
      $display("FAIL %s occupancy: count/full/empty=%0d/%b/%b expected %0d/%b/%b",
               tag, cnt, full, empty, m_count, (m_count == 7), (m_count == 0));
    else n_pass++;
    @(negedge clk);
    e = 1'b0;
    if (!keep_exit) xr = 1'b0;
    if (exp_acc) begin
      exp_f = frame_bits(exp_ent, ts);
      cap = '0; stray = 1'b0; bz = 1'b1;
      for (int i = 0; i < NB; i++) begin
        @(posedge clk); #1;
        cap[NB-1-i] = xo;
        if (ack || rej) stray = 1'b1;
        if (!busy) bz = 1'b0;
      end
      n_total++;
      if (cap !== exp_f)
        $display("FAIL %s frame: x=%b expected %b", tag, cap, exp_f);
      else n_pass++;
      @(posedge clk); #1;
      if (ack || rej) stray = 1'b1;
      n_total++;
      if ({stray, bz, busy, xo} !== 4'b0100)
        $display("FAIL %s framing: stray/busy_held/busy_end/x_end=%b%b%b%b expected 0100",
                 tag, stray, bz, busy, xo);
      else n_pass++;
    end else begin
      n_total++;
      if ({xo, busy} !== 2'b00)
        $display("FAIL %s idle_line: x/busy=%b%b expected 00", tag, xo, busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset_a();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({xo, busy, ack, rej, cnt, full, empty} !== 9'b0000_000_01)
        $display("FAIL reset_state: x/busy/ack/rej/count/full/empty=%b%b%b%b/%0d/%b%b expected 0000/0/01",
                 xo, busy, ack, rej, cnt, full, empty);
      else n_pass++;
    end
  endtask

  task automatic test_entry();
    reset_a();
    txn(1'b1, 1'b0, 3'd5, 1'b0, "entry_slot5");
  endtask

  task automatic test_full();
    reset_a();
    for (int i = 0; i < 7; i++) txn(1'b1, 1'b0, 3'(i), 1'b0, "fill");
    txn(1'b1, 1'b0, 3'd3, 1'b0, "entry_when_full");
    txn(1'b0, 1'b1, 3'd2, 1'b0, "exit_slot2");
  endtask

  task automatic test_both();
    reset_a();
    for (int i = 0; i < 3; i++) txn(1'b1, 1'b0, 3'(i + 1), 1'b0, "pre_both");
    txn(1'b1, 1'b1, 3'd4, 1'b1, "both_entry_wins");
    txn(1'b0, 1'b1, 3'd6, 1'b0, "pending_exit");
  endtask

  task automatic test_empty_rej();
    reset_a();
    txn(1'b0, 1'b1, 3'd3, 1'b0, "exit_when_empty");
  endtask

  task automatic test_mid_reset();
    logic slot_bit;
    reset_a();
    @(negedge clk);
    e = 1'b1; slot = 3'b101;
    @(posedge clk); #1;
    @(negedge clk);
    e = 1'b0;
    repeat (3) @(posedge clk);
    #1 slot_bit = xo;
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({slot_bit, xo, busy, cnt, empty} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b1})
      $display("FAIL mid_frame_reset: slot_bit/x/busy/count/empty=%b/%b/%b/%0d/%b expected 1/0/0/0/1",
               slot_bit, xo, busy, cnt, empty);
    else n_pass++;
    @(negedge clk);
    rst_a = 1'b1;
    m_count = 0;
  endtask

  task automatic test_bit_cycles();
    logic [7:0]  f;
    logic [23:0] exp_v, cap;
    logic        bz;
    f = frame_bits(1'b1, 3'd6);
    exp_v = '0; cap = '0; bz = 1'b1;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < 3; j++)
        exp_v[3*NB-1-(3*i+j)] = f[NB-1-i];
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    e3 = 1'b1; s3 = 3'd6;
    @(posedge clk); #1;
    n_total++;
    if ({ack3, rej3, cnt3, full3, empty3} !== {1'b1, 1'b0, 3'd1, 1'b0, 1'b0})
      $display("FAIL bc3_accept: ack/rej/count/full/empty=%b/%b/%0d/%b/%b expected 1/0/1/0/0",
               ack3, rej3, cnt3, full3, empty3);
    else n_pass++;
    @(negedge clk);
    e3 = 1'b0;
    for (int i = 0; i < 3*NB; i++) begin
      @(posedge clk); #1;
      cap[3*NB-1-i] = x3;
      if (!busy3) bz = 1'b0;
    end
    n_total++;
    if (cap !== exp_v)
      $display("FAIL bc3_frame: x=%b expected %b", cap, exp_v);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({bz, busy3, x3} !== 3'b100)
      $display("FAIL bc3_end: busy_held/busy/x=%b%b%b expected 100", bz, busy3, x3);
    else n_pass++;
  endtask

  task automatic test_random();
    logic te, txr;
    reset_a();
    for (int i = 0; i < 40; i++) begin
      te  = ($urandom_range(0, 9) < 6);
      txr = 1'($urandom_range(0, 1));
      txn(te, txr, 3'($urandom_range(0, 7)), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full();
    test_both();
    test_empty_rej();
    test_mid_reset();
    test_bit_cycles();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
